// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter between the
// Thumb core's fetch and data ports.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        WR      = 3'd2,
        WR_HOLD = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEF_READ_WAIT  = 1;
    localparam int DEF_WRITE_WAIT = 1;

endpackage

// File: rtl/mem_arbiter_timer.sv
// Loadable wait-state down-counter; expired is high once the count reaches zero.
module mem_wait_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_r;

    // Load on grant, then count down while a strobe phase is active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory port between fetch and data requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: data over fetch).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int READ_WAIT  = DEF_READ_WAIT,
    parameter int WRITE_WAIT = DEF_WRITE_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [15:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_n,
    output logic              mem_write_n,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_oe,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W   = 8;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT);

    state_e           state_r;
    logic             port_r;
    logic             req_any_s;
    logic             gnt_port_s;
    logic             load_s;
    logic             dec_s;
    logic             expired_s;
    logic [CNT_W-1:0] load_val_s;

`ifdef MEM_ARB_RR_EN
    logic             last_grant_r;

    // Remember which port was served last so a contended grant alternates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= PORT_I;
        end else if (load_s) begin
            last_grant_r <= gnt_port_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Round-robin pick: contention goes to the port not granted last.
    always_comb begin
        req_any_s = i_req | d_req;
        if (i_req && d_req) begin
            gnt_port_s = (last_grant_r == PORT_I) ? PORT_D : PORT_I;
        end else if (d_req) begin
            gnt_port_s = PORT_D;
        end else begin
            gnt_port_s = PORT_I;
        end
    end
`else
    // Fixed-priority pick: data beats fetch.
    always_comb begin
        req_any_s = i_req | d_req;
        if (d_req) begin
            gnt_port_s = PORT_D;
        end else begin
            gnt_port_s = PORT_I;
        end
    end
`endif

    // Wait-timer control: load on grant, count during strobe phases.
    always_comb begin
        load_s = (state_r == IDLE) && req_any_s;
        dec_s  = (state_r == RD) || (state_r == WR);
        if ((gnt_port_s == PORT_D) && d_we) begin
            load_val_s = WR_LOAD;
        end else begin
            load_val_s = RD_LOAD;
        end
    end

    mem_wait_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_val (load_val_s),
        .dec      (dec_s),
        .expired  (expired_s)
    );

    // Access sequencer; every memory-side and requester-side output is a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            port_r       <= PORT_I;
            mem_addr     <= {ADDR_W{1'b0}};
            mem_wdata    <= {DATA_W{1'b0}};
            mem_read_n   <= 1'b1;
            mem_write_n  <= 1'b1;
            mem_wdata_oe <= 1'b0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            i_rdata      <= 16'h0000;
            d_rdata      <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_any_s) begin
                        port_r <= gnt_port_s;
                        if (gnt_port_s == PORT_D) begin
                            mem_addr <= d_addr;
                            if (d_we) begin
                                mem_wdata    <= d_wdata;
                                mem_write_n  <= 1'b0;
                                mem_wdata_oe <= 1'b1;
                                state_r      <= WR;
                            end else begin
                                mem_read_n <= 1'b0;
                                state_r    <= RD;
                            end
                        end else begin
                            mem_addr   <= i_addr;
                            mem_read_n <= 1'b0;
                            state_r    <= RD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    if (expired_s) begin
                        mem_read_n <= 1'b1;
                        state_r    <= DONE;
                        if (port_r == PORT_D) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
                            i_ack   <= 1'b1;
                        end
                    end else begin
                        state_r <= RD;
                    end
                end
                WR: begin
                    if (expired_s) begin
                        mem_write_n <= 1'b1;
                        state_r     <= WR_HOLD;
                    end else begin
                        state_r <= WR;
                    end
                end
                WR_HOLD: begin
                    mem_wdata_oe <= 1'b0;
                    d_ack        <= 1'b1;
                    state_r      <= DONE;
                end
                DONE: begin
                    // Deliberately no grant here: a req held through its ack waits one idle cycle.
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    mem_read_n   <= 1'b1;
                    mem_write_n  <= 1'b1;
                    mem_wdata_oe <= 1'b0;
                    i_ack        <= 1'b0;
                    d_ack        <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// requesters checked every cycle against a transaction-level timing model.
module tb_mem_arbiter;

    localparam int RW = 1;
    localparam int WW = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] i_rdata;
    logic        i_ack, d_ack, mem_read_n, mem_write_n, mem_wdata_oe;

    // second instance with READ_WAIT=0, WRITE_WAIT=3 for the wait-state boundary checks
    logic        f_i_req, f_d_req, f_d_we;
    logic [31:0] f_i_addr, f_d_addr, f_d_wdata, f_d_rdata, f_mem_addr, f_mem_wdata;
    logic [15:0] f_i_rdata;
    logic        f_i_ack, f_d_ack, f_read_n, f_write_n, f_oe;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_read_n(mem_read_n), .mem_write_n(mem_write_n),
        .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_WAIT(0), .WRITE_WAIT(3)) dut_fast (
        .clk(clk), .reset(reset),
        .i_req(f_i_req), .i_addr(f_i_addr), .i_ack(f_i_ack), .i_rdata(f_i_rdata),
        .d_req(f_d_req), .d_we(f_d_we), .d_addr(f_d_addr), .d_wdata(f_d_wdata),
        .d_ack(f_d_ack), .d_rdata(f_d_rdata),
        .mem_addr(f_mem_addr), .mem_read_n(f_read_n), .mem_write_n(f_write_n),
        .mem_wdata(f_mem_wdata), .mem_wdata_oe(f_oe), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_p counts clock edges since the grant edge; each access occupies a
    // fixed window: read = RW+1 strobe cycles, ack, idle; write = WW+1 strobe
    // cycles, hold, ack, idle.
    bit          m_act, m_port, m_we, m_last;
    int          m_p;
    logic [31:0] e_addr, e_wdata, e_drdata;
    logic [15:0] e_irdata;

    function automatic bit pick_data(input bit ir, input bit dr, input bit last);
`ifdef MEM_ARB_RR_EN
        if (ir && dr) return (last == 1'b0);
        return dr;
`else
        return dr;
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act <= 1'b0; m_p <= 0; m_last <= 1'b0; m_port <= 1'b0; m_we <= 1'b0;
            e_addr <= 32'h0; e_wdata <= 32'h0; e_drdata <= 32'h0; e_irdata <= 16'h0;
        end else if (m_act) begin
            if (!m_we && (m_p + 1 == RW + 1)) begin
                if (m_port) e_drdata <= mem_rdata;
                else        e_irdata <= e_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
            end
            if (m_p + 1 == (m_we ? WW + 3 : RW + 2)) m_act <= 1'b0;
            m_p <= m_p + 1;
        end else if (i_req || d_req) begin
            m_act  <= 1'b1;
            m_p    <= 0;
            m_port <= pick_data(i_req, d_req, m_last);
            m_last <= pick_data(i_req, d_req, m_last);
            m_we   <= pick_data(i_req, d_req, m_last) && d_we;
            e_addr <= pick_data(i_req, d_req, m_last) ? d_addr : i_addr;
            if (pick_data(i_req, d_req, m_last) && d_we) e_wdata <= d_wdata;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        check("mem_read_n",   32'(mem_read_n),   32'(!(m_act && !m_we && m_p <= RW)));
        check("mem_write_n",  32'(mem_write_n),  32'(!(m_act && m_we && m_p <= WW)));
        check("mem_wdata_oe", 32'(mem_wdata_oe), 32'(m_act && m_we && m_p <= WW + 1));
        check("i_ack",        32'(i_ack),        32'(m_act && !m_port && m_p == RW + 1));
        check("d_ack",        32'(d_ack),        32'(m_act && m_port && m_p == (m_we ? WW + 2 : RW + 1)));
        check("mem_addr",     mem_addr,  e_addr);
        check("mem_wdata",    mem_wdata, e_wdata);
        check("i_rdata",      32'(i_rdata), 32'(e_irdata));
        check("d_rdata",      d_rdata,   e_drdata);
    end

    // ---------------- stimulus ----------------
    int j_ack, j_i, j_d, lo, oe_cnt, acks;
    bit first_d;

    initial begin
        reset = 1'b1;
        {i_req, d_req, d_we} = 3'b000;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
        {f_i_req, f_d_req, f_d_we} = 3'b000;
        f_i_addr = 32'h0; f_d_addr = 32'h0; f_d_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_read_n", 32'(mem_read_n), 32'h1);
        check("rst_write_n", 32'(mem_write_n), 32'h1);
        check("rst_oe", 32'(mem_wdata_oe), 32'h0);
        check("rst_acks", 32'({i_ack, d_ack}), 32'h0);
        check("rst_rdata", d_rdata | 32'(i_rdata) | mem_addr | mem_wdata, 32'h0);
        #1 reset = 1'b0;

        // Fetch of the upper halfword
        repeat (2) @(negedge clk); #1;
        i_addr = 32'h6; mem_rdata = 32'h2909_20FC; i_req = 1'b1;
        j_ack = 0; lo = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (!mem_read_n) lo++;
            if (i_ack) begin j_ack = j; break; end
        end
        #1 i_req = 1'b0;
        check("fetch_rdata", 32'(i_rdata), 32'h2909);
        check("fetch_ack_cycle", j_ack, 3);
        check("fetch_strobe_len", lo, 2);

        // Store
        repeat (2) @(negedge clk); #1;
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h24; d_req = 1'b1;
        j_ack = 0; lo = 0; oe_cnt = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (!mem_write_n) begin
                lo++;
                check("store_addr", mem_addr, 32'h100);
                check("store_wdata", mem_wdata, 32'h24);
            end
            if (mem_wdata_oe) oe_cnt++;
            if (d_ack) begin j_ack = j; break; end
        end
        #1 begin d_req = 1'b0; d_we = 1'b0; end
        check("store_ack_cycle", j_ack, 4);
        check("store_strobe_len", lo, 2);
        check("store_oe_len", oe_cnt, 3);

        // Simultaneous reads
        repeat (2) @(negedge clk); #1;
        i_addr = 32'h40; d_addr = 32'h80; i_req = 1'b1; d_req = 1'b1; mem_rdata = 32'hA5A5_5A5A;
        j_i = 0; j_d = 0;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (d_ack) j_d = j;
            if (i_ack) j_i = j;
            #1;
            if (d_ack) d_req = 1'b0;
            if (i_ack) i_req = 1'b0;
            if (j_i != 0 && j_d != 0) break;
        end
`ifdef MEM_ARB_RR_EN
        check("sim_first_i", j_i, 3);
        check("sim_second_d", j_d, 7);
`else
        check("sim_first_d", j_d, 3);
        check("sim_second_i", j_i, 7);
`endif

        // Request held high through its ack: one ack per 4-cycle access
        repeat (2) @(negedge clk); #1;
        i_addr = 32'h2; i_req = 1'b1; acks = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (i_ack) acks++;
        end
        #1 i_req = 1'b0;
        check("held_req_acks", acks, 3);

        // Reset pulse during RD
        repeat (2) @(negedge clk); #1;
        i_addr = 32'h10; i_req = 1'b1;
        @(negedge clk);
        check("rd_strobe_before_rst", 32'(mem_read_n), 32'h0);
        #2 reset = 1'b1;
        #1 check("rd_strobe_async_rst", 32'(mem_read_n), 32'h1);
        acks = 0;
        repeat (2) begin @(negedge clk); if (i_ack) acks++; end
        check("no_ack_in_rst", acks, 0);
        #1 reset = 1'b0;
        j_ack = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (i_ack) begin j_ack = j; break; end
        end
        #1 i_req = 1'b0;
        check("regrant_after_rst", j_ack, 3);

        // READ_WAIT=0 / WRITE_WAIT=3 instance
        repeat (2) @(negedge clk); #1;
        f_i_addr = 32'h0; mem_rdata = 32'h1234_BEEF; f_i_req = 1'b1;
        j_ack = 0; lo = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (!f_read_n) lo++;
            if (f_i_ack) begin j_ack = j; break; end
        end
        #1 f_i_req = 1'b0;
        check("fast_rd_len", lo, 1);
        check("fast_rd_ack", j_ack, 2);
        check("fast_rd_data", 32'(f_i_rdata), 32'hBEEF);
        repeat (2) @(negedge clk); #1;
        f_d_we = 1'b1; f_d_addr = 32'h200; f_d_wdata = 32'h55; f_d_req = 1'b1;
        j_ack = 0; lo = 0; oe_cnt = 0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (!f_write_n) lo++;
            if (f_oe) oe_cnt++;
            if (f_d_ack) begin j_ack = j; break; end
        end
        #1 begin f_d_req = 1'b0; f_d_we = 1'b0; end
        check("fast_wr_len", lo, 4);
        check("fast_wr_oe", oe_cnt, 5);
        check("fast_wr_ack", j_ack, 6);

        // Randomized requesters against the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk); #1;
            mem_rdata = $urandom;
            if (i_req && i_ack) begin
                if ($urandom_range(0, 1) == 0) i_req = 1'b0;
                else i_addr = $urandom;
            end else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            if (d_req && d_ack) begin
                if ($urandom_range(0, 1) == 0) d_req = 1'b0;
                else begin d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom; end
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
            end
        end
        @(negedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
